tree_result_merge: RTL and testbench
====================================

TREE_RESULT_MERGE -- requirements
Module: tree_result_merge

Interface
REQ-001 Parameter PACKET_WIDTH, 104, packet header width per lane.
REQ-002 Parameter NODE_WIDTH, 40, tree node word width; bit 0 = leaf/matched flag.
REQ-003 Parameter RULE_ID, 14, rule-ID field width, located at node[RULE_ID:1].
REQ-004 Parameter FIFO_DEPTH, 4, entries per lane FIFO; power of two, minimum 2.
REQ-005 clk  in  1  single clock; all flops rising-edge.
REQ-006 RST  in  1  asynchronous, active-high reset.
REQ-007 packet_in1/packet_in2  in  PACKET_WIDTH  last tree stage packet, lane 1/2.
REQ-008 data_valid_in1/data_valid_in2  in  1  lane entry valid; no upstream stall exists.
REQ-009 node_in1/node_in2  in  NODE_WIDTH  final node word per lane.
REQ-010 matched_in1/matched_in2  in  1  leaf reached per lane.
REQ-011 res_valid  out  1  result available.
REQ-012 res_ready  in  1  consumer accepts result.
REQ-013 res_packet  out  PACKET_WIDTH  packet of the delivered result.
REQ-014 res_rule_id  out  RULE_ID  matched rule ID; all-ones on miss.
REQ-015 res_hit  out  1  copy of matched flag.
REQ-016 res_lane  out  1  source lane: 0 = lane 1, 1 = lane 2.
REQ-017 drop_cnt1/drop_cnt2  out  16  per-lane overflow drop count, saturating.

Function
REQ-018 Each lane SHALL push {packet, hit, rule_id} into its own FIFO on any rising edge where data_valid_in is 1 and that FIFO is not full.
REQ-019 rule_id SHALL be node_in[RULE_ID:1] when matched_in=1, else all ones (14'h3FFF at default).
REQ-020 A push to a full FIFO SHALL be discarded, and the lane drop counter SHALL increment by 1, saturating at 16'hFFFF.
REQ-021 The output register SHALL load when (!res_valid || res_ready) and at least one FIFO is non-empty; it pops exactly one entry.
REQ-022 If (!res_valid || res_ready) and both FIFOs are empty, res_valid SHALL go 0 on that edge.
REQ-023 Arbitration SHALL be round-robin: with both FIFOs non-empty, grant the lane not granted last; with one non-empty, grant that lane.
REQ-024 The last-grant pointer SHALL update only on a pop.
REQ-025 Minimum latency SHALL be 2 edges: entry sampled at edge k gives res_valid=1 after edge k+1; no FIFO bypass path.
REQ-026 Push and pop on the same FIFO in one cycle SHALL both occur, including when full; the incoming entry is kept and no drop is counted.
REQ-027 While res_valid=1 and res_ready=0, all res_* outputs SHALL hold stable.
REQ-028 Ordering within a lane SHALL be preserved; no entry may be duplicated.

Reset
REQ-029 On RST=1, regardless of clk: res_valid=0, res_packet=0, res_rule_id=0, res_hit=0, res_lane=0, drop counters=0, FIFOs empty, last-grant=lane 2 (lane 1 wins first tie).
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries; after deassertion, the first accepted entry behaves as after power-up.

Structure
REQ-031 NODE_WIDTH, PACKET_WIDTH, RULE_ID, the leaf-flag bit index and the miss rule-ID constant SHALL live in the shared tree package used by all tree stages.
REQ-032 Sub-module result_fifo (synchronous FIFO with full/empty, registered storage) SHALL be instantiated once per lane.

Verification
REQ-033 Single hit: lane 1 valid, matched=1, node=40'h00_0000_0155 (rule 14'h0AA) at edge 0, res_ready=1 -> res_valid=1 after edge 1, res_rule_id=14'h0AA, res_hit=1, res_lane=0.
REQ-034 Miss: lane 2 valid, matched=0 -> res_rule_id=14'h3FFF, res_hit=0, res_lane=1.
REQ-035 Tie: both lanes valid on the same edge for 3 cycles, res_ready=1 -> lanes alternate 0,1,0,1,0,1 with per-lane order preserved.
REQ-036 Overflow: res_ready=0, lane 1 valid for 7 cycles -> 1 entry in the output register, 4 in the FIFO, drop_cnt1=2; then res_ready=1 -> exactly 5 results delivered.
REQ-037 Backpressure: res_ready toggled 1,0,0,1 while both lanes are active -> outputs stable while stalled, no loss or duplication.
REQ-038 Mid-stream reset: RST pulsed with 3 entries buffered -> res_valid=0 immediately, counters=0, the next input is delivered 2 edges later.

Source files
------------

// File: rtl/tree_result_merge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tree_result_merge_pkg
// Description : Shared tree package. Holds the node/packet geometry, the
//               leaf-flag bit index, the rule-ID miss constant and the lane
//               identifiers used by the result merge stage.
// Revision    : 1.0 - initial release
// ============================================================================
package tree_result_merge_pkg;

    localparam int TREE_NODE_WIDTH   = 40;
    localparam int TREE_PACKET_WIDTH = 104;
    localparam int TREE_RULE_ID      = 14;
    localparam int TREE_LEAF_BIT     = 0;

    // A miss reports an all-ones rule ID.
    localparam logic [TREE_RULE_ID-1:0] TREE_MISS_RULE_ID = '1;

    // Source lane of a merged result; encoding matches the res_lane output.
    typedef enum logic {
        LANE_1 = 1'b0,
        LANE_2 = 1'b1
    } lane_e;

endpackage : tree_result_merge_pkg
`default_nettype wire

// File: rtl/tree_result_merge_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : result_fifo
// Description : Synchronous FIFO with registered storage and full/empty flags.
//               A push while full is accepted when a pop happens in the same
//               cycle. Pops while empty are ignored.
// Ports       : clk, rst (async, active-high), i_push, i_pop, i_wr_data,
//               o_rd_data (head entry), o_full, o_empty
// Revision    : 1.0 - initial release
// ============================================================================
module result_fifo #(
    parameter int WIDTH = 119,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rd_data = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only visible behind the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wr_data;
    end

endmodule : result_fifo
`default_nettype wire

// File: rtl/tree_result_merge.sv
`default_nettype none
// ============================================================================
// Module      : tree_result_merge
// Description : Merges the two lanes of the last tree stage into a single
//               valid/ready result stream. Each lane buffers
//               {packet, hit, rule_id} in its own FIFO; a round-robin
//               arbiter fills one output register. Overflowing pushes are
//               dropped and counted per lane (saturating).
// Ports       : clk, RST (async, active-high)
//               packet_in1/2, data_valid_in1/2, node_in1/2, matched_in1/2
//               res_valid, res_ready, res_packet, res_rule_id, res_hit,
//               res_lane (0 = lane 1, 1 = lane 2), drop_cnt1/2
// Revision    : 1.0 - initial release
// ============================================================================
module tree_result_merge
    import tree_result_merge_pkg::*;
#(
    parameter int PACKET_WIDTH = TREE_PACKET_WIDTH,
    parameter int NODE_WIDTH   = TREE_NODE_WIDTH,
    parameter int RULE_ID      = TREE_RULE_ID,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic [PACKET_WIDTH-1:0] packet_in1,
    input  logic [PACKET_WIDTH-1:0] packet_in2,
    input  logic                    data_valid_in1,
    input  logic                    data_valid_in2,
    input  logic [NODE_WIDTH-1:0]   node_in1,
    input  logic [NODE_WIDTH-1:0]   node_in2,
    input  logic                    matched_in1,
    input  logic                    matched_in2,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [PACKET_WIDTH-1:0] res_packet,
    output logic [RULE_ID-1:0]      res_rule_id,
    output logic                    res_hit,
    output logic                    res_lane,
    output logic [15:0]             drop_cnt1,
    output logic [15:0]             drop_cnt2
);

    localparam int c_ENTRY_W = PACKET_WIDTH + 1 + RULE_ID;

    logic [1:0]              w_in_valid;
    logic [1:0]              w_in_match;
    logic [PACKET_WIDTH-1:0] w_in_pkt   [2];
    logic [NODE_WIDTH-1:0]   w_in_node  [2];
    logic [c_ENTRY_W-1:0]    w_wr_entry [2];
    logic [c_ENTRY_W-1:0]    w_rd_entry [2];
    logic [1:0]              w_push;
    logic [1:0]              w_pop;
    logic [1:0]              w_full;
    logic [1:0]              w_empty;
    logic [15:0]             r_drop_cnt [2];

    logic                    w_can_load;
    logic                    w_load;
    lane_e                   w_grant;
    lane_e                   r_last_grant;
    logic [c_ENTRY_W-1:0]    w_sel_entry;

    logic                    r_res_valid;
    logic [PACKET_WIDTH-1:0] r_res_packet;
    logic [RULE_ID-1:0]      r_res_rule_id;
    logic                    r_res_hit;
    logic                    r_res_lane;

    // Only the rule field of the node word is consumed; the leaf flag is
    // redundant with matched_in.
    logic                    w_unused_node;
    assign w_unused_node = ^{node_in1, node_in2};

    assign w_in_valid   = {data_valid_in2, data_valid_in1};
    assign w_in_match   = {matched_in2, matched_in1};
    assign w_in_pkt[0]  = packet_in1;
    assign w_in_pkt[1]  = packet_in2;
    assign w_in_node[0] = node_in1;
    assign w_in_node[1] = node_in2;

    // ------------------------------------------------------------------
    // Per-lane entry formation, FIFO and drop counter
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [RULE_ID-1:0] w_rule;
        logic               w_drop;

        assign w_rule = w_in_match[gi] ? w_in_node[gi][TREE_LEAF_BIT+1 +: RULE_ID]
                                       : {RULE_ID{1'b1}};
        assign w_wr_entry[gi] = {w_in_pkt[gi], w_in_match[gi], w_rule};

        // A full FIFO still accepts when it is being popped this cycle.
        assign w_push[gi] = w_in_valid[gi] && (!w_full[gi] || w_pop[gi]);
        assign w_drop     = w_in_valid[gi] &&  w_full[gi] && !w_pop[gi];

        result_fifo #(
            .WIDTH (c_ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (RST),
            .i_push    (w_push[gi]),
            .i_pop     (w_pop[gi]),
            .i_wr_data (w_wr_entry[gi]),
            .o_rd_data (w_rd_entry[gi]),
            .o_full    (w_full[gi]),
            .o_empty   (w_empty[gi])
        );

        always_ff @(posedge clk or posedge RST) begin
            if (RST) begin
                r_drop_cnt[gi] <= '0;
            end else if (w_drop && (r_drop_cnt[gi] != 16'hFFFF)) begin
                r_drop_cnt[gi] <= r_drop_cnt[gi] + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration: lane 2 wins only if it has data and either
    // lane 1 is empty or lane 1 was granted last.
    // ------------------------------------------------------------------
    assign w_can_load  = !r_res_valid || res_ready;
    assign w_load      = w_can_load && !(w_empty[0] && w_empty[1]);
    assign w_grant     = (!w_empty[1] && (w_empty[0] || (r_last_grant == LANE_1)))
                         ? LANE_2 : LANE_1;
    assign w_pop[0]    = w_load && (w_grant == LANE_1);
    assign w_pop[1]    = w_load && (w_grant == LANE_2);
    assign w_sel_entry = (w_grant == LANE_2) ? w_rd_entry[1] : w_rd_entry[0];

    // ------------------------------------------------------------------
    // Output register; holds while stalled, clears valid when drained.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_res_valid   <= 1'b0;
            r_res_packet  <= '0;
            r_res_rule_id <= '0;
            r_res_hit     <= 1'b0;
            r_res_lane    <= 1'b0;
            r_last_grant  <= LANE_2;
        end else if (w_can_load) begin
            r_res_valid <= w_load;
            if (w_load) begin
                r_res_packet  <= w_sel_entry[c_ENTRY_W-1 -: PACKET_WIDTH];
                r_res_hit     <= w_sel_entry[RULE_ID];
                r_res_rule_id <= w_sel_entry[RULE_ID-1:0];
                r_res_lane    <= w_grant;
                r_last_grant  <= w_grant;
            end
        end
    end

    assign res_valid   = r_res_valid;
    assign res_packet  = r_res_packet;
    assign res_rule_id = r_res_rule_id;
    assign res_hit     = r_res_hit;
    assign res_lane    = r_res_lane;
    assign drop_cnt1   = r_drop_cnt[0];
    assign drop_cnt2   = r_drop_cnt[1];

endmodule : tree_result_merge
`default_nettype wire

// File: tb/tb_tree_result_merge.sv
`default_nettype none
// ============================================================================
// Module      : tb_tree_result_merge
// Description : Self-checking bench for tree_result_merge. Directed vector
//               table, hand-written corner sequences and randomized traffic
//               compared against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tree_result_merge;

    localparam int PW    = 104;
    localparam int NW    = 40;
    localparam int RW    = 14;
    localparam int DEPTH = 4;

    logic          clk;
    logic          RST;
    logic [PW-1:0] packet_in1, packet_in2;
    logic          data_valid_in1, data_valid_in2;
    logic [NW-1:0] node_in1, node_in2;
    logic          matched_in1, matched_in2;
    logic          res_valid, res_ready;
    logic [PW-1:0] res_packet;
    logic [RW-1:0] res_rule_id;
    logic          res_hit, res_lane;
    logic [15:0]   drop_cnt1, drop_cnt2;

    tree_result_merge #(
        .PACKET_WIDTH (PW),
        .NODE_WIDTH   (NW),
        .RULE_ID      (RW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .RST            (RST),
        .packet_in1     (packet_in1),
        .packet_in2     (packet_in2),
        .data_valid_in1 (data_valid_in1),
        .data_valid_in2 (data_valid_in2),
        .node_in1       (node_in1),
        .node_in2       (node_in2),
        .matched_in1    (matched_in1),
        .matched_in2    (matched_in2),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_packet     (res_packet),
        .res_rule_id    (res_rule_id),
        .res_hit        (res_hit),
        .res_lane       (res_lane),
        .drop_cnt1      (drop_cnt1),
        .drop_cnt2      (drop_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [PW-1:0] pkt;
        logic          hit;
        logic [RW-1:0] rule;
        logic          lane;
    } res_t;

    res_t q1[$];
    res_t q2[$];
    logic m_valid;
    res_t m_out;
    logic m_last;
    int   m_drop1, m_drop2;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic res_t mk(input logic [PW-1:0] p, input logic m,
                                input logic [NW-1:0] n, input logic lane);
        res_t r;
        r.pkt  = p;
        r.hit  = m;
        r.rule = m ? n[RW:1] : {RW{1'b1}};
        r.lane = lane;
        return r;
    endfunction

    task automatic model_reset();
        q1.delete();
        q2.delete();
        m_valid = 1'b0;
        m_last  = 1'b1;
        m_drop1 = 0;
        m_drop2 = 0;
        m_out   = '{default: '0};
    endtask

    // One clock edge: deliver/refill the output slot from the pre-edge
    // queues, then apply this edge's arrivals.
    task automatic model_edge();
        if (!m_valid || res_ready) begin
            if (q1.size() > 0 && (q2.size() == 0 || m_last == 1'b1)) begin
                m_out = q1.pop_front(); m_valid = 1'b1; m_last = 1'b0;
            end else if (q2.size() > 0) begin
                m_out = q2.pop_front(); m_valid = 1'b1; m_last = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (data_valid_in1) begin
            if (q1.size() < DEPTH) q1.push_back(mk(packet_in1, matched_in1, node_in1, 1'b0));
            else if (m_drop1 < 65535) m_drop1++;
        end
        if (data_valid_in2) begin
            if (q2.size() < DEPTH) q2.push_back(mk(packet_in2, matched_in2, node_in2, 1'b1));
            else if (m_drop2 < 65535) m_drop2++;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, res_valid, m_valid);
        if (m_valid) begin
            check({tag, ".packet"}, res_packet, m_out.pkt);
            check({tag, ".rule"}, res_rule_id, m_out.rule);
            check({tag, ".hit"}, res_hit, m_out.hit);
            check({tag, ".lane"}, res_lane, m_out.lane);
        end
        check({tag, ".drop1"}, drop_cnt1, m_drop1[15:0]);
        check({tag, ".drop2"}, drop_cnt2, m_drop2[15:0]);
    endtask

    task automatic drive(input logic v1, input logic m1, input logic [NW-1:0] n1,
                         input logic [PW-1:0] p1, input logic v2, input logic m2,
                         input logic [NW-1:0] n2, input logic [PW-1:0] p2, input logic rdy);
        data_valid_in1 = v1; matched_in1 = m1; node_in1 = n1; packet_in1 = p1;
        data_valid_in2 = v2; matched_in2 = m2; node_in2 = n2; packet_in2 = p2;
        res_ready      = rdy;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input int n, input logic rdy, input string tag);
        drive(0, 0, '0, '0, 0, 0, '0, '0, rdy);
        repeat (n) cycle(tag);
    endtask

    task automatic do_reset();
        drive(0, 0, '0, '0, 0, 0, '0, '0, 1'b0);
        RST = 1'b1;
        repeat (2) @(posedge clk);
        #1 RST = 1'b0;
        model_reset();
    endtask

    function automatic logic [PW-1:0] rand_pkt();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[PW-1:0];
    endfunction

    function automatic logic [NW-1:0] rand_node();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[NW-1:0];
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          lane;
        logic          matched;
        logic [NW-1:0] node;
        logic [PW-1:0] pkt;
        logic [RW-1:0] exp_rule;
        logic          exp_hit;
        logic          exp_lane;
    } vec_t;

    vec_t vt[5];

    logic          exp_tie_lane[6];
    logic [PW-1:0] exp_tie_pkt[6];
    logic          got_lane[$];
    logic [PW-1:0] got_pkt[$];
    res_t          held;
    int            cnt;
    logic [3:0]    rpat;

    initial begin
        vt[0] = '{1'b0, 1'b1, 40'h00_0000_0155, 104'h1111, 14'h00AA, 1'b1, 1'b0};
        vt[1] = '{1'b1, 1'b0, 40'h00_0000_0155, 104'h2222, 14'h3FFF, 1'b0, 1'b1};
        vt[2] = '{1'b1, 1'b1, 40'hFF_FFFF_8001, 104'h3333, 14'h0000, 1'b1, 1'b1};
        vt[3] = '{1'b0, 1'b0, 40'h00_0001_FFFE, 104'h4444, 14'h3FFF, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b1, 40'h00_0000_3FFF, 104'h5555, 14'h1FFF, 1'b1, 1'b0};
        exp_tie_lane = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_tie_pkt  = '{104'hA0, 104'hB0, 104'hA1, 104'hB1, 104'hA2, 104'hB2};

        // ---- asynchronous reset state, before any clock edge ----
        RST = 1'b0;
        drive(0, 0, '0, '0, 0, 0, '0, '0, 1'b0);
        model_reset();
        #2 RST = 1'b1;
        #1;
        check("rst.valid", res_valid, 1'b0);
        check("rst.packet", res_packet, '0);
        check("rst.rule", res_rule_id, '0);
        check("rst.hit", res_hit, 1'b0);
        check("rst.lane", res_lane, 1'b0);
        check("rst.drop1", drop_cnt1, 16'd0);
        check("rst.drop2", drop_cnt2, 16'd0);
        @(posedge clk);
        #1 RST = 1'b0;
        model_reset();

        // ---- tie: both lanes for 3 cycles, lane 1 first after reset ----
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 40'h2, 104'hA0 + 104'(i), 1, 1, 40'h4, 104'hB0 + 104'(i), 1'b1);
            cycle("tie");
            if (res_valid) begin got_lane.push_back(res_lane); got_pkt.push_back(res_packet); end
        end
        drive(0, 0, '0, '0, 0, 0, '0, '0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            cycle("tie");
            if (res_valid) begin got_lane.push_back(res_lane); got_pkt.push_back(res_packet); end
        end
        check("tie.count", got_lane.size(), 6);
        for (int i = 0; i < 6 && i < got_lane.size(); i++) begin
            check($sformatf("tie.lane%0d", i), got_lane[i], exp_tie_lane[i]);
            check($sformatf("tie.pkt%0d", i), got_pkt[i], exp_tie_pkt[i]);
        end

        // ---- directed vector table: hit/miss/rule-field boundaries ----
        for (int i = 0; i < 5; i++) begin
            if (vt[i].lane == 1'b0)
                drive(1, vt[i].matched, vt[i].node, vt[i].pkt, 0, 0, '0, '0, 1'b1);
            else
                drive(0, 0, '0, '0, 1, vt[i].matched, vt[i].node, vt[i].pkt, 1'b1);
            cycle("vec");
            check($sformatf("vec%0d.no_bypass", i), res_valid, 1'b0);
            drive(0, 0, '0, '0, 0, 0, '0, '0, 1'b1);
            cycle("vec");
            check($sformatf("vec%0d.valid", i), res_valid, 1'b1);
            check($sformatf("vec%0d.rule", i), res_rule_id, vt[i].exp_rule);
            check($sformatf("vec%0d.hit", i), res_hit, vt[i].exp_hit);
            check($sformatf("vec%0d.lane", i), res_lane, vt[i].exp_lane);
            check($sformatf("vec%0d.packet", i), res_packet, vt[i].pkt);
            cycle("vec");
            check($sformatf("vec%0d.drain", i), res_valid, 1'b0);
        end

        // ---- overflow: 7 pushes with no consumer ----
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1, 1, 40'h10, 104'hC0 + 104'(i), 0, 0, '0, '0, 1'b0);
            cycle("ovf");
        end
        idle(1, 1'b0, "ovf");
        check("ovf.drop1", drop_cnt1, 16'd2);
        check("ovf.drop2", drop_cnt2, 16'd0);
        check("ovf.head", res_packet, 104'hC0);
        cnt = res_valid ? 1 : 0;
        drive(0, 0, '0, '0, 0, 0, '0, '0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle("ovf");
            if (res_valid) cnt++;
        end
        check("ovf.delivered", cnt, 5);

        // ---- backpressure: ready 1,0,0,1 with both lanes active ----
        do_reset();
        rpat = 4'b1001;
        for (int i = 0; i < 16; i++) begin
            drive(1, i[0], rand_node(), 104'hD00 + 104'(i), 1, i[1], rand_node(),
                  104'hE00 + 104'(i), rpat[i % 4]);
            held = m_out;
            if (m_valid && !res_ready) begin
                cycle("bp");
                check("bp.hold_pkt", res_packet, held.pkt);
                check("bp.hold_rule", res_rule_id, held.rule);
                check("bp.hold_lane", res_lane, held.lane);
                check("bp.hold_valid", res_valid, 1'b1);
            end else begin
                cycle("bp");
            end
        end
        idle(12, 1'b1, "bp");

        // ---- mid-stream reset with 3 entries buffered ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 40'h20, 104'hF0 + 104'(i), 0, 0, '0, '0, 1'b0);
            cycle("mrst");
        end
        drive(0, 0, '0, '0, 0, 0, '0, '0, 1'b0);
        #1 RST = 1'b1;
        #1;
        check("mrst.valid", res_valid, 1'b0);
        check("mrst.packet", res_packet, '0);
        check("mrst.drop1", drop_cnt1, 16'd0);
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
        model_reset();
        drive(0, 0, '0, '0, 1, 1, 40'h0000_0000_0006, 104'h77, 1'b1);
        cycle("mrst");
        check("mrst.first_edge", res_valid, 1'b0);
        drive(0, 0, '0, '0, 0, 0, '0, '0, 1'b1);
        cycle("mrst");
        check("mrst.second_edge", res_valid, 1'b1);
        check("mrst.lane", res_lane, 1'b1);
        check("mrst.rule", res_rule_id, 14'h0003);
        check("mrst.packet", res_packet, 104'h77);
        idle(4, 1'b1, "mrst");

        // ---- randomized traffic against the model ----
        do_reset();
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), rand_node(), rand_pkt(),
                  $urandom_range(0, 1), $urandom_range(0, 1), rand_node(), rand_pkt(),
                  ($urandom_range(0, 3) != 0));
            cycle("rand");
        end
        idle(12, 1'b1, "rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tree_result_merge
`default_nettype wire
